// File: rtl/apb_master_bridge.sv
// apb_master_bridge: turns a host valid/ready request into an APB4 SETUP/ACCESS
// transfer on one of two slaves and returns a one-cycle response pulse. An
// optional ACCESS-phase wait-state limit aborts hung transfers with rsp_err.
module apb_master_bridge #(
    parameter int           ADDR_WIDTH   = 32,
    parameter int           DATA_WIDTH   = 32,
    parameter int           STRB_WIDTH   = DATA_WIDTH / 8,
    parameter int           SEL_BIT      = 12,
    parameter int           TIMEOUT      = 16,
    parameter logic [1:0]   IDLE_PHASE   = 2'b00,
    parameter logic [1:0]   SETUP_PHASE  = 2'b01,
    parameter logic [1:0]   ACCESS_PHASE = 2'b10
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [STRB_WIDTH-1:0] req_strb,
    input  logic [2:0]            req_prot,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic [2:0]            PPROT,
    output logic                  PSEL0,
    output logic                  PSEL1,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [DATA_WIDTH-1:0] PWDATA,
    output logic [STRB_WIDTH-1:0] PSTRB,
    input  logic                  PREADY,
    input  logic [DATA_WIDTH-1:0] PRDATA
);

    typedef enum logic [1:0] {
        IDLE   = IDLE_PHASE,
        SETUP  = SETUP_PHASE,
        ACCESS = ACCESS_PHASE
    } state_t;

    state_t                state, state_nxt;
    logic [31:0]           wait_cnt, wait_cnt_nxt;
    logic                  accept;
    logic                  timeout_hit;

    logic [ADDR_WIDTH-1:0] paddr_nxt;
    logic [2:0]            pprot_nxt;
    logic                  psel0_nxt, psel1_nxt, penable_nxt, pwrite_nxt;
    logic [DATA_WIDTH-1:0] pwdata_nxt;
    logic [STRB_WIDTH-1:0] pstrb_nxt;
    logic                  rsp_valid_nxt, rsp_err_nxt;
    logic [DATA_WIDTH-1:0] rsp_rdata_nxt;

    // A new request can enter when idle, or on the completion edge of the
    // current transfer so back-to-back requests skip the IDLE cycle.
    assign req_ready   = (state == IDLE) || ((state == ACCESS) && PREADY);
    assign accept      = req_valid && req_ready;
    assign timeout_hit = (TIMEOUT != 0) && (wait_cnt == 32'(TIMEOUT - 1));

    // Next-state and next-output logic; APB outputs hold unless changed below.
    always_comb begin
        state_nxt     = state;
        wait_cnt_nxt  = wait_cnt;
        paddr_nxt     = PADDR;
        pprot_nxt     = PPROT;
        psel0_nxt     = PSEL0;
        psel1_nxt     = PSEL1;
        penable_nxt   = PENABLE;
        pwrite_nxt    = PWRITE;
        pwdata_nxt    = PWDATA;
        pstrb_nxt     = PSTRB;
        rsp_valid_nxt = 1'b0;
        rsp_err_nxt   = rsp_err;
        rsp_rdata_nxt = rsp_rdata;

        case (state)
            IDLE: begin
                psel0_nxt   = 1'b0;
                psel1_nxt   = 1'b0;
                penable_nxt = 1'b0;
            end
            SETUP: begin
                state_nxt    = ACCESS;
                penable_nxt  = 1'b1;
                wait_cnt_nxt = '0;
            end
            ACCESS: begin
                if (PREADY) begin
                    rsp_valid_nxt = 1'b1;
                    rsp_err_nxt   = 1'b0;
                    rsp_rdata_nxt = PWRITE ? '0 : PRDATA;
                    state_nxt     = IDLE;
                    psel0_nxt     = 1'b0;
                    psel1_nxt     = 1'b0;
                    penable_nxt   = 1'b0;
                end else if (timeout_hit) begin
                    rsp_valid_nxt = 1'b1;
                    rsp_err_nxt   = 1'b1;
                    rsp_rdata_nxt = '0;
                    state_nxt     = IDLE;
                    psel0_nxt     = 1'b0;
                    psel1_nxt     = 1'b0;
                    penable_nxt   = 1'b0;
                end else begin
                    wait_cnt_nxt = wait_cnt + 32'd1;
                end
            end
            default: begin
                state_nxt   = IDLE;
                psel0_nxt   = 1'b0;
                psel1_nxt   = 1'b0;
                penable_nxt = 1'b0;
            end
        endcase

        // An accepted request overrides the return to IDLE and starts SETUP;
        // reads drive zero data and zero strobes.
        if (accept) begin
            state_nxt   = SETUP;
            paddr_nxt   = req_addr;
            pprot_nxt   = req_prot;
            pwrite_nxt  = req_write;
            pwdata_nxt  = req_write ? req_wdata : '0;
            pstrb_nxt   = req_write ? req_strb : '0;
            psel0_nxt   = ~req_addr[SEL_BIT];
            psel1_nxt   = req_addr[SEL_BIT];
            penable_nxt = 1'b0;
        end
    end

    // State, counter and every registered output; reset clears all immediately.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            PADDR     <= '0;
            PPROT     <= '0;
            PSEL0     <= 1'b0;
            PSEL1     <= 1'b0;
            PENABLE   <= 1'b0;
            PWRITE    <= 1'b0;
            PWDATA    <= '0;
            PSTRB     <= '0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            state     <= state_nxt;
            wait_cnt  <= wait_cnt_nxt;
            PADDR     <= paddr_nxt;
            PPROT     <= pprot_nxt;
            PSEL0     <= psel0_nxt;
            PSEL1     <= psel1_nxt;
            PENABLE   <= penable_nxt;
            PWRITE    <= pwrite_nxt;
            PWDATA    <= pwdata_nxt;
            PSTRB     <= pstrb_nxt;
            rsp_valid <= rsp_valid_nxt;
            rsp_err   <= rsp_err_nxt;
            rsp_rdata <= rsp_rdata_nxt;
        end
    end

endmodule

// File: tb/tb_apb_master_bridge.sv
// tb_apb_master_bridge: two bridge instances (wait limit 16 and disabled) share
// stimulus; use_t0 routes the host request to one and selects its outputs.
module tb_apb_master_bridge;

    localparam int SEL = 12;

    typedef struct {
        bit          t0;
        bit          write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [2:0]  prot;
        int          waits;
        logic [31:0] prdata;
        logic [31:0] exp_rdata;
        bit          exp_err;
        int          exp_access;
    } vec_t;

    logic        PCLK = 1'b0;
    logic        PRESETn = 1'b0;
    logic        use_t0 = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [3:0]  req_strb = '0;
    logic [2:0]  req_prot = '0;
    logic        PREADY = 1'b0;
    logic [31:0] PRDATA = '0;

    logic        a_ready, a_rv, a_err, a_psel0, a_psel1, a_pen, a_pwrite;
    logic [31:0] a_rdata, a_paddr, a_pwdata;
    logic [3:0]  a_pstrb;
    logic [2:0]  a_pprot;
    logic        b_ready, b_rv, b_err, b_psel0, b_psel1, b_pen, b_pwrite;
    logic [31:0] b_rdata, b_paddr, b_pwdata;
    logic [3:0]  b_pstrb;
    logic [2:0]  b_pprot;

    wire         o_ready  = use_t0 ? b_ready  : a_ready;
    wire         o_rv     = use_t0 ? b_rv     : a_rv;
    wire         o_err    = use_t0 ? b_err    : a_err;
    wire [31:0]  o_rdata  = use_t0 ? b_rdata  : a_rdata;
    wire         o_psel0  = use_t0 ? b_psel0  : a_psel0;
    wire         o_psel1  = use_t0 ? b_psel1  : a_psel1;
    wire         o_pen    = use_t0 ? b_pen    : a_pen;
    wire         o_pwrite = use_t0 ? b_pwrite : a_pwrite;
    wire [31:0]  o_paddr  = use_t0 ? b_paddr  : a_paddr;
    wire [31:0]  o_pwdata = use_t0 ? b_pwdata : a_pwdata;
    wire [3:0]   o_pstrb  = use_t0 ? b_pstrb  : a_pstrb;
    wire [2:0]   o_pprot  = use_t0 ? b_pprot  : a_pprot;

    apb_master_bridge #(.TIMEOUT(16)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .req_valid(req_valid && !use_t0), .req_ready(a_ready),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_strb(req_strb), .req_prot(req_prot),
        .rsp_valid(a_rv), .rsp_rdata(a_rdata), .rsp_err(a_err),
        .PADDR(a_paddr), .PPROT(a_pprot), .PSEL0(a_psel0), .PSEL1(a_psel1),
        .PENABLE(a_pen), .PWRITE(a_pwrite), .PWDATA(a_pwdata), .PSTRB(a_pstrb),
        .PREADY(PREADY), .PRDATA(PRDATA)
    );

    apb_master_bridge #(.TIMEOUT(0)) dut_t0 (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .req_valid(req_valid && use_t0), .req_ready(b_ready),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_strb(req_strb), .req_prot(req_prot),
        .rsp_valid(b_rv), .rsp_rdata(b_rdata), .rsp_err(b_err),
        .PADDR(b_paddr), .PPROT(b_pprot), .PSEL0(b_psel0), .PSEL1(b_psel1),
        .PENABLE(b_pen), .PWRITE(b_pwrite), .PWDATA(b_pwdata), .PSTRB(b_pstrb),
        .PREADY(PREADY), .PRDATA(PRDATA)
    );

    always #5 PCLK = ~PCLK;

    int compared = 0;
    int mismatched = 0;

    task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    function automatic logic [127:0] apbActual();
        logic [127:0] r;
        r = {o_psel0, o_psel1, o_pen, o_paddr, o_pwrite, o_pwdata, o_pstrb, o_pprot};
        return r;
    endfunction

    // Bus values a transfer must show, derived from the request itself.
    function automatic logic [127:0] apbExpected(input vec_t v, input bit en);
        logic [127:0] r;
        r = {~v.addr[SEL], v.addr[SEL], en, v.addr, v.write,
             v.write ? v.wdata : 32'h0, v.write ? v.strb : 4'h0, v.prot};
        return r;
    endfunction

    // Transaction-level reference: response contents and ACCESS length.
    function automatic vec_t model(input vec_t v);
        vec_t r;
        r = v;
        r.exp_err    = !v.t0 && (v.waits >= 16);
        r.exp_access = r.exp_err ? 16 : v.waits + 1;
        r.exp_rdata  = (v.write || r.exp_err) ? 32'h0 : v.prdata;
        return r;
    endfunction

    function automatic vec_t mk(input bit t0, input bit wr, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [3:0] strb,
                                input logic [2:0] prot, input int waits, input logic [31:0] prdata,
                                input logic [31:0] exp_rdata, input bit exp_err, input int exp_access);
        vec_t v;
        v.t0 = t0; v.write = wr; v.addr = addr; v.wdata = wdata; v.strb = strb;
        v.prot = prot; v.waits = waits; v.prdata = prdata; v.exp_rdata = exp_rdata;
        v.exp_err = exp_err; v.exp_access = exp_access;
        return v;
    endfunction

    // One full transfer from an idle bridge, acting as the APB slave.
    task automatic applyStimulus(input vec_t v, input string name);
        int  acc;
        bit  done;
        use_t0    = v.t0;
        req_valid = 1'b1;
        req_write = v.write;
        req_addr  = v.addr;
        req_wdata = v.wdata;
        req_strb  = v.strb;
        req_prot  = v.prot;
        PREADY    = 1'b0;
        @(negedge PCLK);
        req_valid = 1'b0;
        req_addr  = $urandom;
        req_wdata = $urandom;
        checkOutput({name, "_setup"}, apbActual(), apbExpected(v, 1'b0));
        PREADY = 1'($urandom);
        acc  = 0;
        done = 1'b0;
        for (int c = 0; c < 300 && !done; c++) begin
            @(negedge PCLK);
            if (o_rv) begin
                done = 1'b1;
                checkOutput({name, "_rdata"}, o_rdata, v.exp_rdata);
                checkOutput({name, "_err"}, o_err, v.exp_err);
                checkOutput({name, "_idle_bus"}, {o_psel0, o_psel1, o_pen, o_paddr}, {3'b000, v.addr});
            end else begin
                acc++;
                if (acc <= v.exp_access)
                    checkOutput({name, "_access"}, apbActual(), apbExpected(v, 1'b1));
                PREADY = (acc > v.waits);
                PRDATA = PREADY ? v.prdata : $urandom;
            end
        end
        if (!done) checkOutput({name, "_no_response"}, 0, 1);
        checkOutput({name, "_access_cycles"}, acc, v.exp_access);
        PREADY = 1'b0;
        @(negedge PCLK);
        checkOutput({name, "_pulse"}, o_rv, 1'b0);
    endtask

    vec_t        tbl[7];
    logic [31:0] b2b_addr[3] = '{32'h0000_0100, 32'h0000_1104, 32'h0000_0208};

    initial begin
        vec_t v;
        int   k;
        int   setup_cyc[$];
        int   rsp_cyc[$];

        tbl[0] = mk(0, 1, 32'h0000_0010, 32'hDEAD_BEEF, 4'b0101, 3'b000, 0,   32'hAAAA_5555, 32'h0,         0, 1);
        tbl[1] = mk(0, 0, 32'h0000_1004, 32'h1111_2222, 4'b1111, 3'b010, 3,   32'h1234_5678, 32'h1234_5678, 0, 4);
        tbl[2] = mk(0, 0, 32'h0000_0020, 32'h0,         4'b0000, 3'b001, 40,  32'hCAFE_F00D, 32'h0,         1, 16);
        tbl[3] = mk(1, 0, 32'h0000_1100, 32'h0,         4'b0000, 3'b100, 100, 32'h0BAD_C0DE, 32'h0BAD_C0DE, 0, 101);
        tbl[4] = mk(0, 1, 32'h0000_1FFC, 32'h0102_0304, 4'b1111, 3'b111, 15,  32'h7777_7777, 32'h0,         0, 16);
        tbl[5] = mk(0, 0, 32'h0000_3000, 32'h0,         4'b1010, 3'b011, 15,  32'h55AA_55AA, 32'h55AA_55AA, 0, 16);
        tbl[6] = mk(0, 1, 32'h0000_0044, 32'hFFFF_0000, 4'b0011, 3'b000, 16,  32'h1357_9BDF, 32'h0,         1, 16);

        // reset state while PRESETn is held low
        #3;
        checkOutput("reset_bus", apbActual(), 0);
        checkOutput("reset_rsp", {o_rv, o_err, o_rdata}, 0);
        checkOutput("reset_ready", o_ready, 1'b1);
        @(negedge PCLK);
        PRESETn = 1'b1;
        @(negedge PCLK);

        for (int i = 0; i < 7; i++) applyStimulus(tbl[i], $sformatf("vec%0d", i));

        // three back-to-back writes with PREADY held high
        use_t0 = 1'b0;
        PREADY = 1'b1;
        k = 0;
        req_valid = 1'b1; req_write = 1'b1; req_addr = b2b_addr[0];
        req_wdata = 32'hB0B0_0000; req_strb = 4'hF; req_prot = 3'b000;
        for (int c = 1; c <= 12; c++) begin
            @(negedge PCLK);
            if (o_rv) begin
                rsp_cyc.push_back(c);
                checkOutput("b2b_err", o_err, 1'b0);
            end
            if ((o_psel0 || o_psel1) && !o_pen) begin
                setup_cyc.push_back(c);
                if (k < 3) checkOutput("b2b_addr_order", o_paddr, b2b_addr[k]);
                k++;
                if (k < 3) begin
                    req_addr  = b2b_addr[k];
                    req_wdata = 32'hB0B0_0000 + 32'(k);
                end else begin
                    req_valid = 1'b0;
                end
            end
        end
        PREADY = 1'b0;
        checkOutput("b2b_setups", setup_cyc.size(), 3);
        checkOutput("b2b_rsps", rsp_cyc.size(), 3);
        if (setup_cyc.size() == 3 && rsp_cyc.size() == 3) begin
            checkOutput("b2b_setup_gap1", setup_cyc[1] - setup_cyc[0], 2);
            checkOutput("b2b_setup_gap2", setup_cyc[2] - setup_cyc[1], 2);
            checkOutput("b2b_rsp_gap1", rsp_cyc[1] - rsp_cyc[0], 2);
            checkOutput("b2b_rsp_gap2", rsp_cyc[2] - rsp_cyc[1], 2);
            checkOutput("b2b_latency", rsp_cyc[0] - setup_cyc[0], 2);
        end

        // reset asserted in the middle of a stalled read
        @(negedge PCLK);
        use_t0 = 1'b0;
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h0000_0400; req_prot = 3'b101;
        PREADY = 1'b0;
        @(negedge PCLK);
        req_valid = 1'b0;
        @(negedge PCLK);
        checkOutput("rst_pre_access", {o_psel0, o_pen, o_paddr}, {2'b11, 32'h0000_0400});
        @(negedge PCLK);
        #1 PRESETn = 1'b0;
        #1 checkOutput("rst_drop", {o_psel0, o_psel1, o_pen, o_paddr}, 0);
        @(negedge PCLK);
        checkOutput("rst_no_rsp1", o_rv, 1'b0);
        @(negedge PCLK);
        PRESETn = 1'b1;
        @(negedge PCLK);
        checkOutput("rst_no_rsp2", {o_rv, o_psel0, o_psel1, o_pen}, 0);
        applyStimulus(model(mk(0, 0, 32'h0000_1400, 32'h0, 4'h0, 3'b000, 2, 32'h600D_D00D, 0, 0, 0)), "post_rst");

        // randomized transfers checked against the transaction model
        for (int i = 0; i < 40; i++) begin
            v.t0     = 1'($urandom);
            v.write  = 1'($urandom);
            v.addr   = $urandom;
            v.wdata  = $urandom;
            v.strb   = 4'($urandom);
            v.prot   = 3'($urandom);
            v.waits  = int'($urandom_range(0, 20));
            v.prdata = $urandom;
            applyStimulus(model(v), $sformatf("rand%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    // Guard against a hung run.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got no finish expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
